// File: rtl/fproc_pkg.sv
// Shared definitions for the fproc measurement responder: id width, per-core
// FSM state encoding and the fixed response words for error exits.
package fproc_pkg;

  localparam int FPROC_ID_WIDTH = 8;
  localparam int FPROC_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fproc_state_t;

  localparam logic [FPROC_DATA_WIDTH-1:0] TIMEOUT_DATA = '1;
  localparam logic [FPROC_DATA_WIDTH-1:0] BAD_ID_DATA = '0;

endpackage

// File: rtl/fproc_meas_resp_if.sv
// Per-core fproc request/response bundle between the processor cores (master)
// and the measurement responder (slave), plus the responder's FSM state view.
interface fproc_meas_resp_if #(
  parameter int N_CORES = 4,
  parameter int DATA_WIDTH = 32
);

  // Request: fproc_enable[k] is a one-cycle pulse qualifying fproc_id slice k.
  // Response: fproc_ready[k] is a one-cycle pulse qualifying fproc_data slice k;
  // there is no back-pressure, and a core issues no new request until after its
  // ready pulse.
  logic [N_CORES-1:0]                          fproc_enable;
  logic [N_CORES*fproc_pkg::FPROC_ID_WIDTH-1:0] fproc_id;
  logic [N_CORES-1:0]                          fproc_ready;
  logic [N_CORES*DATA_WIDTH-1:0]               fproc_data;
  logic [N_CORES*2-1:0]                        state_dbg;

  modport master (
    output fproc_enable,
    output fproc_id,
    input  fproc_ready,
    input  fproc_data,
    input  state_dbg
  );

  modport slave (
    input  fproc_enable,
    input  fproc_id,
    output fproc_ready,
    output fproc_data,
    output state_dbg
  );

endinterface

// File: rtl/fproc_core_port.sv
// One core's responder: request FSM, latched id, timeout counter, per-channel
// fresh flags and the registered response word.
module fproc_core_port
  import fproc_pkg::*;
#(
  parameter int N_MEAS         = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMO_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [FPROC_ID_WIDTH-1:0] id,
  input  logic [N_MEAS-1:0]         meas_valid,
  input  logic [N_MEAS-1:0]         meas_bit,
  input  logic [N_MEAS-1:0]         meas_reg,
  output logic                      ready,
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      bad_id_pulse,
  output logic                      timeout_pulse,
  output fproc_state_t              state
);

  localparam int IDX_W = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_WIDTH-1:0] TMO_LAST =
    TMO_EN ? TMO_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [DATA_WIDTH-1:0] TMO_WORD =
    (DATA_WIDTH <= FPROC_DATA_WIDTH) ? DATA_WIDTH'(TIMEOUT_DATA) : '1;
  localparam logic [DATA_WIDTH-1:0] BAD_WORD =
    (DATA_WIDTH <= FPROC_DATA_WIDTH) ? DATA_WIDTH'(BAD_ID_DATA) : '0;

  fproc_state_t              state_q, state_d;
  logic [FPROC_ID_WIDTH-1:0] id_q, id_d;
  logic [TMO_WIDTH-1:0]      cnt_q, cnt_d;
  logic [N_MEAS-1:0]         fresh_q, fresh_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      id_ok;
  logic [IDX_W-1:0]          idx;

  assign id_ok = (int'(id_q) < N_MEAS);
  assign idx   = id_q[IDX_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      cnt_q   <= '0;
      fresh_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      fresh_q <= fresh_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    fresh_d       = fresh_q | meas_valid;
    bad_id_pulse  = 1'b0;
    timeout_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          id_d    = id;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!id_ok) begin
          state_d      = RESP;
          data_d       = BAD_WORD;
          bad_id_pulse = 1'b1;
        end else if (meas_valid[idx]) begin
          // The same-cycle strobe is the value consumed, so its fresh flag stays clear.
          state_d      = RESP;
          data_d       = DATA_WIDTH'(meas_bit[idx]);
          fresh_d[idx] = 1'b0;
        end else if (fresh_q[idx]) begin
          state_d      = RESP;
          data_d       = DATA_WIDTH'(meas_reg[idx]);
          fresh_d[idx] = 1'b0;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          state_d       = RESP;
          data_d        = TMO_WORD;
          timeout_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + TMO_WIDTH'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        data_d  = '0;
      end
      default: begin
        state_d = IDLE;
        data_d  = '0;
      end
    endcase
  end

  assign ready = (state_q == RESP);
  assign data  = data_q;
  assign state = state_q;

endmodule

// File: rtl/fproc_meas_resp.sv
// fproc responder top: shared channel result store, one request port per core,
// and sticky error flags collected from all ports.
module fproc_meas_resp
  import fproc_pkg::*;
#(
  parameter int N_CORES        = 4,
  parameter int N_MEAS         = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMO_WIDTH      = 16
) (
  input  logic               clk,
  input  logic               reset,
  fproc_meas_resp_if.slave   fproc,
  input  logic [N_MEAS-1:0]  meas_valid,
  input  logic [N_MEAS-1:0]  meas_bit,
  output logic               err_bad_id,
  output logic               err_timeout
);

  logic [N_MEAS-1:0]  meas_reg;
  logic [N_CORES-1:0] bad_id_pulse;
  logic [N_CORES-1:0] timeout_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meas_reg <= '0;
    end else begin
      meas_reg <= (meas_reg & ~meas_valid) | (meas_bit & meas_valid);
    end
  end

  for (genvar k = 0; k < N_CORES; k++) begin : g_core
    fproc_state_t core_state;

    fproc_core_port #(
      .N_MEAS         (N_MEAS),
      .DATA_WIDTH     (DATA_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TMO_WIDTH      (TMO_WIDTH)
    ) u_port (
      .clk           (clk),
      .reset         (reset),
      .enable        (fproc.fproc_enable[k]),
      .id            (fproc.fproc_id[k*FPROC_ID_WIDTH +: FPROC_ID_WIDTH]),
      .meas_valid    (meas_valid),
      .meas_bit      (meas_bit),
      .meas_reg      (meas_reg),
      .ready         (fproc.fproc_ready[k]),
      .data          (fproc.fproc_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .bad_id_pulse  (bad_id_pulse[k]),
      .timeout_pulse (timeout_pulse[k]),
      .state         (core_state)
    );

    assign fproc.state_dbg[2*k +: 2] = core_state;
  end

  // Error flags hold until reset so software can poll them after the fact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_bad_id  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_bad_id  <= err_bad_id | (|bad_id_pulse);
      err_timeout <= err_timeout | (|timeout_pulse);
    end
  end

endmodule

// File: tb/tb_fproc_meas_resp.sv
// Directed bench for fproc_meas_resp: a vector table of single requests plus
// hand-written stall, broadcast, back-to-back, timeout and reset sequences.
module tb_fproc_meas_resp;
  import fproc_pkg::*;

  localparam int N_CORES = 4;
  localparam int N_MEAS  = 8;
  localparam int DW      = 32;
  localparam int TMO     = 16;
  localparam int N_VEC   = 9;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N_MEAS-1:0] meas_valid = '0;
  logic [N_MEAS-1:0] meas_bit = '0;
  logic              err_bad_id;
  logic              err_timeout;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  fproc_meas_resp_if #(.N_CORES(N_CORES), .DATA_WIDTH(DW)) bus ();

  fproc_meas_resp #(
    .N_CORES        (N_CORES),
    .N_MEAS         (N_MEAS),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO),
    .TMO_WIDTH      (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fproc       (bus),
    .meas_valid  (meas_valid),
    .meas_bit    (meas_bit),
    .err_bad_id  (err_bad_id),
    .err_timeout (err_timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic       pulse;
    int         ch;
    logic       b;
    int         core;
    logic [7:0] id;
    int         lat;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[N_VEC];

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endfunction

  function automatic logic [DW-1:0] data_of(int core);
    return bus.fproc_data[core*DW +: DW];
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_meas(int ch, logic b);
    meas_valid[ch] = 1'b1;
    meas_bit[ch]   = b;
    tick();
    meas_valid = '0;
    meas_bit   = '0;
  endtask

  task automatic drive_enable(int core, logic [7:0] id);
    bus.fproc_enable[core]     = 1'b1;
    bus.fproc_id[core*8 +: 8]  = id;
    tick();
    bus.fproc_enable = '0;
  endtask

  // lat = cycles from the enable cycle to the ready cycle; 0 if the bound expired
  task automatic wait_ready(int core, int max, output int lat);
    lat = 0;
    for (int i = 2; i <= max; i++) begin
      tick();
      if (bus.fproc_ready[core]) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic quiet_ticks(string name, int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      seen = seen | (|bus.fproc_ready);
    end
    check(name, 32'(seen), 32'd0);
  endtask

  // scoreboard: response data is compared against the front of exp_q
  task automatic check_data(string name, int core);
    logic [DW-1:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({name, " data"}, data_of(core), exp);
  endtask

  task automatic check_drop(string name, int core);
    tick();
    check({name, " drop"}, 32'(bus.fproc_ready[core] | (|data_of(core))), 32'd0);
  endtask

  task automatic expect_resp(string name, int core, int exp_lat, int max);
    int lat;
    wait_ready(core, max, lat);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check_data(name, core);
    check_drop(name, core);
  endtask

  initial begin
    int   lat;
    logic bad_seen;

    bus.fproc_enable = '0;
    bus.fproc_id     = '0;

    vecs[0] = '{1'b1, 3, 1'b1, 0, 8'd3,   2, 32'h0000_0001};
    vecs[1] = '{1'b1, 6, 1'b0, 1, 8'd6,   2, 32'h0000_0000};
    vecs[2] = '{1'b0, 0, 1'b0, 2, 8'd3,   2, 32'h0000_0001};
    vecs[3] = '{1'b1, 7, 1'b1, 3, 8'd7,   2, 32'h0000_0001};
    vecs[4] = '{1'b0, 0, 1'b0, 0, 8'd8,   2, 32'h0000_0000};
    vecs[5] = '{1'b0, 0, 1'b0, 1, 8'd200, 2, 32'h0000_0000};
    vecs[6] = '{1'b1, 2, 1'b1, 0, 8'd2,   2, 32'h0000_0001};
    vecs[7] = '{1'b0, 0, 1'b0, 3, 8'd6,   2, 32'h0000_0000};
    vecs[8] = '{1'b1, 1, 1'b1, 1, 8'd1,   2, 32'h0000_0001};

    // reset state
    tick();
    tick();
    check("reset ready", 32'(bus.fproc_ready), 32'd0);
    check("reset data", 32'(|bus.fproc_data), 32'd0);
    check("reset errs", {30'd0, err_bad_id, err_timeout}, 32'd0);
    check("reset state", 32'(bus.state_dbg), 32'd0);
    reset = 1'b1;
    tick();

    // vector table
    bad_seen = 1'b0;
    for (int i = 0; i < N_VEC; i++) begin
      if (vecs[i].pulse) pulse_meas(vecs[i].ch, vecs[i].b);
      exp_q.push_back(vecs[i].data);
      drive_enable(vecs[i].core, vecs[i].id);
      expect_resp($sformatf("vec%0d", i), vecs[i].core, vecs[i].lat, 30);
      bad_seen = bad_seen | (int'(vecs[i].id) >= N_MEAS);
      check($sformatf("vec%0d err_bad_id", i), 32'(err_bad_id), 32'(bad_seen));
    end
    check("table err_timeout", 32'(err_timeout), 32'd0);

    // consumed result stalls until a new strobe; answer one cycle after it
    drive_enable(0, 8'd3);
    quiet_ticks("stall quiet", 10);
    check("stall state", 32'(bus.state_dbg[1:0]), 32'(WAIT));
    meas_valid[3] = 1'b1;
    meas_bit[3]   = 1'b0;
    tick();
    meas_valid = '0;
    exp_q.push_back(32'h0);
    check("stall ready", 32'(bus.fproc_ready[0]), 32'd1);
    check_data("stall", 0);
    check_drop("stall", 0);

    // the bypassed strobe was consumed, so the next request must wait again
    drive_enable(0, 8'd3);
    quiet_ticks("bypass consumed quiet", 3);
    meas_valid[3] = 1'b1;
    meas_bit[3]   = 1'b1;
    tick();
    meas_valid = '0;
    meas_bit   = '0;
    exp_q.push_back(32'h1);
    check("bypass2 ready", 32'(bus.fproc_ready[0]), 32'd1);
    check_data("bypass2", 0);
    check_drop("bypass2", 0);

    // broadcast: two cores on the same channel answered together
    bus.fproc_enable   = 4'b0110;
    bus.fproc_id[15:8]  = 8'd5;
    bus.fproc_id[23:16] = 8'd5;
    tick();
    bus.fproc_enable = '0;
    quiet_ticks("bcast quiet", 5);
    meas_valid[5] = 1'b1;
    meas_bit[5]   = 1'b1;
    tick();
    meas_valid = '0;
    meas_bit   = '0;
    check("bcast ready", 32'(bus.fproc_ready), 32'h6);
    exp_q.push_back(32'h1);
    check_data("bcast core1", 1);
    exp_q.push_back(32'h1);
    check_data("bcast core2", 2);
    tick();
    exp_q.push_back(32'h1);
    drive_enable(3, 8'd5);
    expect_resp("bcast core3", 3, 2, 30);

    // back-to-back: enable during RESP ignored, the next cycle's enable accepted
    meas_valid = 8'h50;
    meas_bit   = 8'h50;
    tick();
    meas_valid = '0;
    meas_bit   = '0;
    exp_q.push_back(32'h1);
    drive_enable(2, 8'd4);
    wait_ready(2, 30, lat);
    check("b2b first latency", 32'(lat), 32'd2);
    check_data("b2b first", 2);
    bus.fproc_enable[2]  = 1'b1;
    bus.fproc_id[23:16]  = 8'd9;
    tick();
    check("b2b gap ready", 32'(bus.fproc_ready[2]), 32'd0);
    bus.fproc_id[23:16] = 8'd6;
    tick();
    bus.fproc_enable = '0;
    exp_q.push_back(32'h1);
    expect_resp("b2b second", 2, 2, 30);

    // timeout
    check("pre timeout err", 32'(err_timeout), 32'd0);
    exp_q.push_back(32'hFFFF_FFFF);
    drive_enable(1, 8'd0);
    expect_resp("timeout", 1, TMO + 1, 60);
    check("timeout err", 32'(err_timeout), 32'd1);

    // reset in the middle of a wait
    drive_enable(0, 8'd3);
    tick();
    check("pre reset state", 32'(bus.state_dbg[1:0]), 32'(WAIT));
    reset = 1'b0;
    #1;
    check("async reset state", 32'(bus.state_dbg), 32'd0);
    check("async reset errs", {30'd0, err_bad_id, err_timeout}, 32'd0);
    quiet_ticks("reset hold quiet", 3);
    check("reset hold data", 32'(|bus.fproc_data), 32'd0);
    reset = 1'b1;
    quiet_ticks("post reset quiet", 3);
    pulse_meas(3, 1'b1);
    exp_q.push_back(32'h1);
    drive_enable(0, 8'd3);
    expect_resp("post reset fresh", 0, 2, 30);
    check("post reset errs", {30'd0, err_bad_id, err_timeout}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
